// File: rtl/usb_fs_line_tx.sv
// usb_fs_line_tx
//
// USB full-speed line transmitter. Packet bytes arrive over a valid/ready
// byte stream. The block prepends SYNC, serialises each byte LSB first,
// inserts stuff bits, NRZI-encodes the result and finishes the packet with
// an EOP (two bit-times of SE0, then one bit-time of J). Each line state is
// held for CLKS_PER_BIT clocks (48 MHz clock, 12 Mb/s bit rate).
//
// Ports:
//   clk       - 48 MHz clock
//   reset_n   - asynchronous reset, active low
//   tx_valid  - tx_data/tx_last hold a byte to send
//   tx_data   - packet byte (PID first), sent LSB first
//   tx_last   - marks the final byte of the packet
//   tx_ready  - holding register empty; a byte transfers on tx_valid && tx_ready
//   oe        - drive the bus
//   dp_tx     - D+ value while oe
//   dn_tx     - D- value while oe
//   busy      - packet in progress
//   underrun  - one-cycle pulse when a packet is cut short for lack of data
module usb_fs_line_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       oe,
  output logic       dp_tx,
  output logic       dn_tx,
  output logic       busy,
  output logic       underrun
);

  localparam int              CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0]   LAST_CLK     = CW'(CLKS_PER_BIT - 1);
  localparam logic [7:0]      SYNC_PATTERN = 8'h80;

  typedef enum logic [2:0] {
    IDLE,
    SYNC,
    DATA,
    STUFF,
    EOP_SE0,
    EOP_J
  } state_t;

  state_t        state;
  logic [CW-1:0] bit_cnt;
  logic [2:0]    bit_idx;
  logic [2:0]    ones;
  logic [7:0]    shift;
  logic          cur_last;
  logic [7:0]    hold;
  logic          hold_last;
  logic          hold_full;
  logic          line_j;

  logic          bit_start;
  logic          bit_end;
  logic          cur_bit;
  logic          next_line;
  logic          byte_boundary;

  assign tx_ready = ~hold_full;

  // Bit-time phase decode plus the raw bit to put on the wire this bit-time.
  // A stuff bit is always a 0, which is the default. NRZI: a 0 toggles the
  // line, a 1 holds it. byte_boundary marks the last clock of data bit 7,
  // or of the stuff bit that follows it when one is pending.
  always_comb begin
    bit_start     = (bit_cnt == '0);
    bit_end       = (bit_cnt == LAST_CLK);
    cur_bit       = 1'b0;
    case (state)
      SYNC:    cur_bit = SYNC_PATTERN[bit_idx];
      DATA:    cur_bit = shift[0];
      default: cur_bit = 1'b0;
    endcase
    next_line     = cur_bit ? line_j : ~line_j;
    byte_boundary = bit_end &&
                    (((state == DATA) && (bit_idx == 3'd7) && (ones != 3'd6)) ||
                     ((state == STUFF) && (bit_idx == 3'd0)));
  end

  // Main sequencer. The line outputs are registered on the first clock of
  // each bit-time, so each line state lasts exactly CLKS_PER_BIT clocks.
  // Next-state and byte-advance decisions are made on the last clock of the
  // bit-time. The holding register fills whenever it is empty, whatever the
  // state, so a byte offered during EOP or IDLE starts the next packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      bit_idx   <= 3'd0;
      ones      <= 3'd0;
      shift     <= 8'h00;
      cur_last  <= 1'b0;
      hold      <= 8'h00;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      line_j    <= 1'b1;
      oe        <= 1'b0;
      dp_tx     <= 1'b1;
      dn_tx     <= 1'b0;
      busy      <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= 1'b0;

      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end

      if (state != IDLE) begin
        bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          oe      <= 1'b0;
          dp_tx   <= 1'b1;
          dn_tx   <= 1'b0;
          line_j  <= 1'b1;
          bit_cnt <= '0;
          bit_idx <= 3'd0;
          ones    <= 3'd0;
          busy    <= hold_full;
          if (hold_full) begin
            shift     <= hold;
            cur_last  <= hold_last;
            hold_full <= 1'b0;
            state     <= SYNC;
          end
        end

        SYNC: begin
          if (bit_start) begin
            oe     <= 1'b1;
            line_j <= next_line;
            dp_tx  <= next_line;
            dn_tx  <= ~next_line;
          end
          if (bit_end) begin
            bit_idx <= bit_idx + 3'd1;
            // The closing SYNC 1 starts the run of ones for stuffing.
            if (bit_idx == 3'd7) begin
              ones  <= 3'd1;
              state <= DATA;
            end
          end
        end

        DATA: begin
          if (bit_start) begin
            oe     <= 1'b1;
            line_j <= next_line;
            dp_tx  <= next_line;
            dn_tx  <= ~next_line;
            ones   <= cur_bit ? ones + 3'd1 : 3'd0;
          end
          if (bit_end) begin
            shift   <= shift >> 1;
            bit_idx <= bit_idx + 3'd1;
            if (ones == 3'd6) begin
              state <= STUFF;
            end
          end
        end

        STUFF: begin
          if (bit_start) begin
            oe     <= 1'b1;
            line_j <= next_line;
            dp_tx  <= next_line;
            dn_tx  <= ~next_line;
            ones   <= 3'd0;
          end
          if (bit_end && (bit_idx != 3'd0)) begin
            state <= DATA;
          end
        end

        EOP_SE0: begin
          if (bit_start) begin
            oe    <= 1'b1;
            dp_tx <= 1'b0;
            dn_tx <= 1'b0;
          end
          if (bit_end) begin
            if (bit_idx == 3'd1) begin
              bit_idx <= 3'd0;
              state   <= EOP_J;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end

        EOP_J: begin
          if (bit_start) begin
            oe     <= 1'b1;
            dp_tx  <= 1'b1;
            dn_tx  <= 1'b0;
            line_j <= 1'b1;
          end
          if (bit_end) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase

      // End of a byte: finish the packet, chain the next byte, or give up.
      if (byte_boundary) begin
        if (cur_last) begin
          state <= EOP_SE0;
        end else if (hold_full) begin
          shift     <= hold;
          cur_last  <= hold_last;
          hold_full <= 1'b0;
          state     <= DATA;
        end else begin
          underrun <= 1'b1;
          state    <= EOP_SE0;
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_fs_line_tx.sv
// tb_usb_fs_line_tx
//
// Self-checking bench for usb_fs_line_tx. Expected line activity comes from a
// packet-level model: build the raw bit stream (SYNC then bytes LSB first),
// insert a 0 after every six consecutive 1s, NRZI-encode starting from J,
// then append SE0, SE0, J, each bit-time expanded to four clocks.
module tb_usb_fs_line_tx;

  localparam int LIM = 3000;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_ready;
  logic       oe;
  logic       dp_tx;
  logic       dn_tx;
  logic       busy;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int acc_q[$];
  int ur_cnt = 0;
  int ur_edge = -1;
  int oe_rise_edge = -1;
  int oe_fall_edge = -1;
  int busy_rise_edge = -1;
  int busy_fall_edge = -1;
  int se0_edge = -1;
  int oe_gap = -1;
  logic prev_oe = 1'b0;
  logic prev_busy = 1'b0;
  logic prev_se0 = 1'b0;

  logic [8:0] pkt_q[$];
  logic [1:0] exp_clk[$];
  logic [1:0] cap_q[$];

  usb_fs_line_tx #(.CLKS_PER_BIT(4)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .oe       (oe),
    .dp_tx    (dp_tx),
    .dn_tx    (dn_tx),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 clk = ~clk;

  // Edge counter and record of accepted bytes (edge index of each handshake).
  always @(posedge clk) begin
    if (reset_n && tx_valid && tx_ready) acc_q.push_back(cyc);
    cyc = cyc + 1;
  end

  // Event monitor sampling away from the active edge; times are edge indices.
  always @(negedge clk) begin
    if (underrun === 1'b1) begin
      ur_cnt  = ur_cnt + 1;
      ur_edge = cyc - 1;
    end
    if (oe === 1'b1 && prev_oe !== 1'b1) begin
      oe_rise_edge = cyc - 1;
      if (oe_fall_edge >= 0) oe_gap = oe_rise_edge - oe_fall_edge;
    end
    if (oe !== 1'b1 && prev_oe === 1'b1) oe_fall_edge = cyc - 1;
    if (busy === 1'b1 && prev_busy !== 1'b1) busy_rise_edge = cyc - 1;
    if (busy !== 1'b1 && prev_busy === 1'b1) busy_fall_edge = cyc - 1;
    if (oe === 1'b1 && dp_tx === 1'b0 && dn_tx === 1'b0 && !prev_se0) se0_edge = cyc - 1;
    prev_se0  = (oe === 1'b1 && dp_tx === 1'b0 && dn_tx === 1'b0);
    prev_oe   = (oe === 1'b1);
    prev_busy = (busy === 1'b1);
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Packet-level reference model for the bytes in pkt_q.
  task automatic build_model();
    logic raw[$];
    logic stuffed[$];
    int   ones;
    logic lvl;
    exp_clk.delete();
    for (int i = 0; i < 7; i++) raw.push_back(1'b0);
    raw.push_back(1'b1);
    foreach (pkt_q[k]) for (int i = 0; i < 8; i++) raw.push_back(pkt_q[k][i]);
    ones = 0;
    foreach (raw[i]) begin
      stuffed.push_back(raw[i]);
      if (raw[i]) ones++; else ones = 0;
      if (ones == 6) begin
        stuffed.push_back(1'b0);
        ones = 0;
      end
    end
    lvl = 1'b1;
    foreach (stuffed[i]) begin
      if (!stuffed[i]) lvl = ~lvl;
      repeat (4) exp_clk.push_back({lvl, ~lvl});
    end
    repeat (8) exp_clk.push_back(2'b00);
    repeat (4) exp_clk.push_back(2'b10);
  endtask

  // Offers the bytes of pkt_q one at a time with random idle gaps.
  task automatic send_packet(input int max_gap);
    for (int i = 0; i < pkt_q.size(); i++) begin
      int n;
      int gap;
      gap = (i == 0) ? 0 : int'($urandom_range(max_gap, 0));
      if (gap > 0) begin
        tx_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      tx_valid = 1'b1;
      tx_data  = pkt_q[i][7:0];
      tx_last  = pkt_q[i][8];
      n = 0;
      while (tx_ready !== 1'b1 && n < LIM) begin
        @(negedge clk);
        n++;
      end
      if (n >= LIM) begin
        checks++;
        errors++;
        $display("[TB] FAIL send_timeout: byte %0d never accepted, expected tx_ready", i);
        tx_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  // Records {dp_tx,dn_tx} every clock of the next oe-high window.
  task automatic capture();
    int n = 0;
    cap_q.delete();
    while (oe !== 1'b0 && n < LIM) begin @(negedge clk); n++; end
    while (oe !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    while (oe === 1'b1 && n < LIM) begin
      cap_q.push_back({dp_tx, dn_tx});
      @(negedge clk);
      n++;
    end
    if (n >= LIM) begin
      checks++;
      errors++;
      $display("[TB] FAIL capture_timeout: oe window not seen, expected a packet");
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || oe !== 1'b0) && n < LIM) begin @(negedge clk); n++; end
    if (n >= LIM) begin
      checks++;
      errors++;
      $display("[TB] FAIL idle_timeout: busy=%b oe=%b, expected 0/0", busy, oe);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (oe !== 1'b0) begin errors++; $display("[TB] FAIL reset_oe: got %b expected 0", oe); end
    checks++; if (dp_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_dp: got %b expected 1", dp_tx); end
    checks++; if (dn_tx !== 1'b0) begin errors++; $display("[TB] FAIL reset_dn: got %b expected 0", dn_tx); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b expected 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_underrun: got %b expected 0", underrun); end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_idle: oe=%b busy=%b expected 0/0", oe, busy); end
  endtask

  task automatic test_single_zero();
    int bad = -1;
    pkt_q = '{9'h100};
    build_model();
    acc_q.delete();
    ur_cnt = 0;
    fork
      send_packet(0);
      capture();
    join
    wait_idle();
    for (int i = 0; i < exp_clk.size() && i < cap_q.size(); i++) if (bad < 0 && cap_q[i] !== exp_clk[i]) bad = i;
    checks++; if (cap_q.size() != exp_clk.size()) begin errors++; $display("[TB] FAIL zero_len: got %0d clocks expected %0d", cap_q.size(), exp_clk.size()); end
    checks++; if (bad >= 0) begin errors++; $display("[TB] FAIL zero_line clk %0d: got %b expected %b", bad, cap_q[bad], exp_clk[bad]); end
    checks++; if (oe_fall_edge - oe_rise_edge != 76) begin errors++; $display("[TB] FAIL zero_oe_time: got %0d expected 76", oe_fall_edge - oe_rise_edge); end
    checks++; if (acc_q.size() < 1 || oe_rise_edge - acc_q[0] != 2) begin errors++; $display("[TB] FAIL start_latency: got %0d expected 2", oe_rise_edge - (acc_q.size() > 0 ? acc_q[0] : 0)); end
    checks++; if (acc_q.size() < 1 || busy_rise_edge - acc_q[0] != 1) begin errors++; $display("[TB] FAIL busy_rise: got %0d expected 1", busy_rise_edge - (acc_q.size() > 0 ? acc_q[0] : 0)); end
    checks++; if (busy_fall_edge != oe_fall_edge) begin errors++; $display("[TB] FAIL busy_fall: got edge %0d expected %0d", busy_fall_edge, oe_fall_edge); end
    checks++; if (ur_cnt != 0) begin errors++; $display("[TB] FAIL zero_underrun: got %0d expected 0", ur_cnt); end
  endtask

  task automatic test_single_ff();
    int bad = -1;
    pkt_q = '{9'h1FF};
    build_model();
    ur_cnt = 0;
    fork
      send_packet(0);
      capture();
    join
    wait_idle();
    for (int i = 0; i < exp_clk.size() && i < cap_q.size(); i++) if (bad < 0 && cap_q[i] !== exp_clk[i]) bad = i;
    checks++; if (cap_q.size() != exp_clk.size()) begin errors++; $display("[TB] FAIL ff_len: got %0d clocks expected %0d", cap_q.size(), exp_clk.size()); end
    checks++; if (bad >= 0) begin errors++; $display("[TB] FAIL ff_line clk %0d: got %b expected %b", bad, cap_q[bad], exp_clk[bad]); end
    checks++; if (oe_fall_edge - oe_rise_edge != 80) begin errors++; $display("[TB] FAIL ff_oe_time: got %0d expected 80", oe_fall_edge - oe_rise_edge); end
    checks++; if (ur_cnt != 0) begin errors++; $display("[TB] FAIL ff_underrun: got %0d expected 0", ur_cnt); end
  endtask

  task automatic test_back_to_back();
    int bad = -1;
    pkt_q = '{9'h0C3, 9'h15A};
    build_model();
    acc_q.delete();
    ur_cnt = 0;
    fork
      send_packet(0);
      capture();
    join
    wait_idle();
    for (int i = 0; i < exp_clk.size() && i < cap_q.size(); i++) if (bad < 0 && cap_q[i] !== exp_clk[i]) bad = i;
    checks++; if (bad >= 0 || cap_q.size() != exp_clk.size()) begin errors++; $display("[TB] FAIL b2b_line first bad clk %0d: got len %0d expected len %0d", bad, cap_q.size(), exp_clk.size()); end
    checks++; if (oe_fall_edge - oe_rise_edge != 108) begin errors++; $display("[TB] FAIL b2b_oe_time: got %0d expected 108", oe_fall_edge - oe_rise_edge); end
    checks++; if (acc_q.size() != 2 || acc_q[1] - acc_q[0] != 2) begin errors++; $display("[TB] FAIL b2b_second_accept: got %0d accepts, spacing expected 2", acc_q.size()); end
    checks++; if (ur_cnt != 0) begin errors++; $display("[TB] FAIL b2b_underrun: got %0d expected 0", ur_cnt); end
  endtask

  task automatic test_underrun();
    int bad = -1;
    pkt_q = '{9'h02D};
    build_model();
    ur_cnt = 0;
    fork
      send_packet(0);
      capture();
    join
    wait_idle();
    for (int i = 0; i < exp_clk.size() && i < cap_q.size(); i++) if (bad < 0 && cap_q[i] !== exp_clk[i]) bad = i;
    checks++; if (bad >= 0 || cap_q.size() != exp_clk.size()) begin errors++; $display("[TB] FAIL ur_line first bad clk %0d: got len %0d expected len %0d", bad, cap_q.size(), exp_clk.size()); end
    checks++; if (ur_cnt != 1) begin errors++; $display("[TB] FAIL ur_pulses: got %0d expected 1", ur_cnt); end
    checks++; if (se0_edge != ur_edge + 1) begin errors++; $display("[TB] FAIL ur_se0_start: got %0d expected %0d", se0_edge, ur_edge + 1); end
    checks++; if (oe_fall_edge != se0_edge + 12) begin errors++; $display("[TB] FAIL ur_oe_fall: got %0d expected %0d", oe_fall_edge, se0_edge + 12); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL ur_ready: got %b expected 1", tx_ready); end
  endtask

  task automatic test_reset_mid_packet();
    int n = 0;
    int bad = -1;
    pkt_q = '{{1'b1, 8'($urandom)}};
    send_packet(0);
    while (oe !== 1'b1 && n < LIM) begin @(negedge clk); n++; end
    checks++; if (n >= LIM) begin errors++; $display("[TB] FAIL rst_wait_oe: oe=%b expected 1", oe); end
    repeat (45) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (oe !== 1'b0 || dp_tx !== 1'b1 || dn_tx !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_line: got oe=%b dp=%b dn=%b expected 0/1/0", oe, dp_tx, dn_tx); end
    checks++; if (busy !== 1'b0 || tx_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_async_flags: got busy=%b ready=%b expected 0/1", busy, tx_ready); end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (tx_ready !== 1'b1 || oe !== 1'b0) begin errors++; $display("[TB] FAIL rst_release: got ready=%b oe=%b expected 1/0", tx_ready, oe); end
    pkt_q = '{9'h1A5};
    build_model();
    ur_cnt = 0;
    fork
      send_packet(0);
      capture();
    join
    wait_idle();
    for (int i = 0; i < exp_clk.size() && i < cap_q.size(); i++) if (bad < 0 && cap_q[i] !== exp_clk[i]) bad = i;
    checks++; if (cap_q.size() < 1 || cap_q[0] !== 2'b01) begin errors++; $display("[TB] FAIL rst_first_k: got %b expected 01", cap_q.size() > 0 ? cap_q[0] : 2'bxx); end
    checks++; if (bad >= 0 || cap_q.size() != exp_clk.size()) begin errors++; $display("[TB] FAIL rst_restart_line first bad clk %0d: got len %0d expected len %0d", bad, cap_q.size(), exp_clk.size()); end
  endtask

  task automatic test_eop_j_accept();
    int n = 0;
    int bad = -1;
    pkt_q = '{9'h100};
    send_packet(0);
    while (!(oe === 1'b1 && dp_tx === 1'b0 && dn_tx === 1'b0) && n < LIM) begin @(negedge clk); n++; end
    while (!(oe === 1'b1 && dp_tx === 1'b1 && dn_tx === 1'b0) && n < LIM) begin @(negedge clk); n++; end
    checks++; if (n >= LIM) begin errors++; $display("[TB] FAIL eopj_wait: EOP J not seen, expected within %0d clocks", LIM); end
    pkt_q = '{9'h13C};
    build_model();
    oe_gap = -1;
    ur_cnt = 0;
    fork
      send_packet(0);
      capture();
    join
    wait_idle();
    for (int i = 0; i < exp_clk.size() && i < cap_q.size(); i++) if (bad < 0 && cap_q[i] !== exp_clk[i]) bad = i;
    checks++; if (oe_gap != 1) begin errors++; $display("[TB] FAIL eopj_gap: got %0d clocks of oe low expected 1", oe_gap); end
    checks++; if (bad >= 0 || cap_q.size() != exp_clk.size()) begin errors++; $display("[TB] FAIL eopj_line first bad clk %0d: got len %0d expected len %0d", bad, cap_q.size(), exp_clk.size()); end
    checks++; if (ur_cnt != 0) begin errors++; $display("[TB] FAIL eopj_underrun: got %0d expected 0", ur_cnt); end
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      int len;
      int bad;
      logic [7:0] b;
      len = int'($urandom_range(4, 1));
      pkt_q.delete();
      for (int i = 0; i < len; i++) begin
        b = ($urandom_range(3, 0) == 0) ? 8'hFF : 8'($urandom);
        pkt_q.push_back({(i == len - 1), b});
      end
      build_model();
      ur_cnt = 0;
      fork
        send_packet(8);
        capture();
      join
      wait_idle();
      bad = -1;
      for (int i = 0; i < exp_clk.size() && i < cap_q.size(); i++) if (bad < 0 && cap_q[i] !== exp_clk[i]) bad = i;
      checks++; if (bad >= 0 || cap_q.size() != exp_clk.size()) begin errors++; $display("[TB] FAIL rand_line pkt %0d first bad clk %0d: got len %0d expected len %0d", p, bad, cap_q.size(), exp_clk.size()); end
      checks++; if (ur_cnt != 0) begin errors++; $display("[TB] FAIL rand_underrun pkt %0d: got %0d expected 0", p, ur_cnt); end
    end
  endtask

  initial begin
    $display("[TB] starting usb_fs_line_tx bench");
    test_reset();
    test_single_zero();
    test_single_ff();
    test_back_to_back();
    test_underrun();
    test_reset_mid_packet();
    test_eop_j_accept();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
